// File: rtl/iob_dma_desc_sched_pkg.sv
// Shared types and constants for the iob_dma descriptor scheduler.
// CSR offsets are byte addresses in the iob_dma register map.
package iob_dma_desc_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_IF,
        WR_DIR,
        WR_A,
        WR_B,
        SETTLE,
        RD_REQ,
        RD_WAIT,
        DONE
    } sched_state_e;

    localparam int unsigned CSR_BASE_ADDR     = 'h00;
    localparam int unsigned CSR_TRANSFER_SIZE = 'h04;
    localparam int unsigned CSR_DIRECTION     = 'h08;
    localparam int unsigned CSR_INTERFACE_NUM = 'h0C;
    localparam int unsigned CSR_READY_W       = 'h10;
    localparam int unsigned CSR_READY_R       = 'h14;

    localparam logic [3:0] WSTRB_WORD = 4'hF;

    // Packed descriptor layout is {addr, size, dir, if, tag}.
    function automatic int unsigned desc_width(input int unsigned aw, input int unsigned sw,
                                               input int unsigned iw, input int unsigned tw);
        return aw + sw + 1 + iw + tw;
    endfunction

endpackage

// File: rtl/iob_dma_desc_sched_if.sv
// IOb native bus between the scheduler (master) and the iob_dma CSR port (slave).
interface iob_dma_desc_sched_if #(
    parameter int CSR_ADDR_W = 5
) ();
    logic                  iob_valid;
    logic [CSR_ADDR_W-1:0] iob_addr;
    logic [31:0]           iob_wdata;
    logic [3:0]            iob_wstrb;
    logic                  iob_ready;
    logic                  iob_rvalid;
    logic [31:0]           iob_rdata;

    modport master (
        output iob_valid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_ready, iob_rvalid, iob_rdata
    );

    modport slave (
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
        output iob_ready, iob_rvalid, iob_rdata
    );
endinterface

// File: rtl/iob_dma_desc_fifo.sv
// Register-based descriptor FIFO with synchronous flush and first-word-fall-through read.
module iob_dma_desc_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             cke_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [DEPTH_LOG2-1:0] rptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  doPush;
    logic                  doPop;

    // Count never exceeds DEPTH, so its top bit alone marks full.
    assign full_o  = count_q[DEPTH_LOG2];
    assign empty_o = (count_q == '0);
    assign doPush  = push_i & ~full_o & ~flush_i;
    assign doPop   = pop_i & ~empty_o & ~flush_i;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (cke_i) begin
            if (flush_i) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (doPush) wptr_q <= wptr_q + 1'b1;
                if (doPop)  rptr_q <= rptr_q + 1'b1;
                case ({doPush, doPop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset; entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (cke_i && doPush) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/iob_dma_desc_sched.sv
// Descriptor scheduler: queues DMA descriptors, programs them into the iob_dma CSRs,
// polls the READY flag and reports completion with the descriptor tag.
module iob_dma_desc_sched
    import iob_dma_desc_sched_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SIZE_W     = 32,
    parameter int IF_W       = 4,
    parameter int TAG_W      = 4,
    parameter int DEPTH_LOG2 = 2,
    parameter int CSR_ADDR_W = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              flush_i,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [ADDR_W-1:0] desc_addr_i,
    input  logic [SIZE_W-1:0] desc_size_i,
    input  logic              desc_dir_i,
    input  logic [IF_W-1:0]   desc_if_i,
    input  logic [TAG_W-1:0]  desc_tag_i,
    output logic              done_valid_o,
    output logic [TAG_W-1:0]  done_tag_o,
    output logic              busy_o,
    iob_dma_desc_sched_if.master iob_m
);
    localparam int DESC_W = int'(desc_width(ADDR_W, SIZE_W, IF_W, TAG_W));

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] workAddr_q, workAddr_d;
    logic [SIZE_W-1:0] workSize_q, workSize_d;
    logic              workDir_q, workDir_d;
    logic [IF_W-1:0]   workIf_q, workIf_d;
    logic [TAG_W-1:0]  workTag_q, workTag_d;
    logic [3:0]        settleCnt_q, settleCnt_d;
    logic              doneValid_q, doneValid_d;
    logic [TAG_W-1:0]  doneTag_q, doneTag_d;

    logic [DESC_W-1:0] fifoWdata;
    logic [DESC_W-1:0] fifoRdata;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              headAvail;
    logic              popReq;
    logic [ADDR_W-1:0] headAddr;
    logic [SIZE_W-1:0] headSize;
    logic              headDir;
    logic [IF_W-1:0]   headIf;
    logic [TAG_W-1:0]  headTag;

    logic                  iobValid;
    logic [CSR_ADDR_W-1:0] iobAddr;
    logic [31:0]           iobWdata;
    logic [3:0]            iobWstrb;
    logic [30:0]           unusedRdata;

    assign fifoWdata = {desc_addr_i, desc_size_i, desc_dir_i, desc_if_i, desc_tag_i};
    assign {headAddr, headSize, headDir, headIf, headTag} = fifoRdata;

    // A head that is being flushed this cycle is not allowed to start.
    assign headAvail = ~fifoEmpty & ~flush_i;
    assign popReq    = (state_q == IDLE) & headAvail;

    iob_dma_desc_fifo #(
        .WIDTH      (DESC_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .cke_i   (cke_i),
        .flush_i (flush_i),
        .push_i  (desc_valid_i),
        .wdata_i (fifoWdata),
        .pop_i   (popReq),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            workAddr_q  <= '0;
            workSize_q  <= '0;
            workDir_q   <= 1'b0;
            workIf_q    <= '0;
            workTag_q   <= '0;
            settleCnt_q <= '0;
            doneValid_q <= 1'b0;
            doneTag_q   <= '0;
        end else if (cke_i) begin
            state_q     <= state_d;
            workAddr_q  <= workAddr_d;
            workSize_q  <= workSize_d;
            workDir_q   <= workDir_d;
            workIf_q    <= workIf_d;
            workTag_q   <= workTag_d;
            settleCnt_q <= settleCnt_d;
            doneValid_q <= doneValid_d;
            doneTag_q   <= doneTag_d;
        end
    end

    // Receive arms the size counter before the address write starts the writer;
    // send programs the address first because the size write kicks off the read side.
    always_comb begin
        state_d     = state_q;
        workAddr_d  = workAddr_q;
        workSize_d  = workSize_q;
        workDir_d   = workDir_q;
        workIf_d    = workIf_q;
        workTag_d   = workTag_q;
        settleCnt_d = settleCnt_q;
        iobValid    = 1'b0;
        iobAddr     = '0;
        iobWdata    = '0;
        iobWstrb    = '0;

        case (state_q)
            IDLE: begin
                if (headAvail) begin
                    workAddr_d = headAddr;
                    workSize_d = headSize;
                    workDir_d  = headDir;
                    workIf_d   = headIf;
                    workTag_d  = headTag;
                    state_d    = (headSize == '0) ? DONE : WR_IF;
                end
            end
            WR_IF: begin
                iobValid = 1'b1;
                iobAddr  = CSR_ADDR_W'(CSR_INTERFACE_NUM);
                iobWdata = 32'(workIf_q);
                iobWstrb = WSTRB_WORD;
                if (iob_m.iob_ready) state_d = WR_DIR;
            end
            WR_DIR: begin
                iobValid = 1'b1;
                iobAddr  = CSR_ADDR_W'(CSR_DIRECTION);
                iobWdata = 32'(workDir_q);
                iobWstrb = WSTRB_WORD;
                if (iob_m.iob_ready) state_d = WR_A;
            end
            WR_A: begin
                iobValid = 1'b1;
                iobAddr  = workDir_q ? CSR_ADDR_W'(CSR_TRANSFER_SIZE) : CSR_ADDR_W'(CSR_BASE_ADDR);
                iobWdata = workDir_q ? 32'(workSize_q) : 32'(workAddr_q);
                iobWstrb = WSTRB_WORD;
                if (iob_m.iob_ready) state_d = WR_B;
            end
            WR_B: begin
                iobValid = 1'b1;
                iobAddr  = workDir_q ? CSR_ADDR_W'(CSR_BASE_ADDR) : CSR_ADDR_W'(CSR_TRANSFER_SIZE);
                iobWdata = workDir_q ? 32'(workAddr_q) : 32'(workSize_q);
                iobWstrb = WSTRB_WORD;
                settleCnt_d = '0;
                if (iob_m.iob_ready) state_d = SETTLE;
            end
            SETTLE: begin
                // The DMA raises its start pulse late; a READY read too early would see the old 1.
                settleCnt_d = settleCnt_q + 1'b1;
                if (settleCnt_q == 4'(SETTLE_CYC - 1)) state_d = RD_REQ;
            end
            RD_REQ: begin
                iobValid = 1'b1;
                iobAddr  = workDir_q ? CSR_ADDR_W'(CSR_READY_W) : CSR_ADDR_W'(CSR_READY_R);
                if (iob_m.iob_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (iob_m.iob_rvalid) state_d = iob_m.iob_rdata[0] ? DONE : RD_REQ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        doneValid_d = (state_d == DONE);
        doneTag_d   = (state_d == DONE) ? workTag_d : doneTag_q;
    end

    assign unusedRdata = iob_m.iob_rdata[31:1];

    assign iob_m.iob_valid = iobValid;
    assign iob_m.iob_addr  = iobAddr;
    assign iob_m.iob_wdata = iobWdata;
    assign iob_m.iob_wstrb = iobWstrb;

    assign desc_ready_o = ~fifoFull;
    assign done_valid_o = doneValid_q;
    assign done_tag_o   = doneTag_q;
    assign busy_o       = (state_q != IDLE) | ~fifoEmpty;

endmodule
